sprite_bitmap_loader: RTL and testbench

//  Writer end of the sprite bitmap ROM interface. Receives bitmaps over a byte stream and checks

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_ram_dp.sv | 38 +++
 rtl/sprite_bitmap_loader.sv | 146 ++++++++++++++
 tb/tb_sprite_bitmap_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, FSM states and address layout for the sprite bitmap loader.
// Header byte is {idx[2:0], magic[4:0]}; RAM address is {bitmap, row, half}.
package sprite_pkg;

  localparam int unsigned BITMAP_BYTES = 32;
  localparam logic [4:0]  MAGIC        = 5'h1A;
  localparam logic [4:0]  CNT_LAST     = 5'(BITMAP_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    COMMIT
  } state_e;

  typedef struct packed {
    logic [2:0] idx;
    logic [4:0] magic;
  } hdr_t;

  typedef struct packed {
    logic [2:0] bitmap;
    logic [3:0] row;
    logic       half;
  } rd_addr_t;

endpackage

// File: rtl/sprite_ram_dp.sv
// 256x8 sprite RAM: synchronous write, registered read with 1-cycle latency, read-before-write.
// No backpressure; the read port is always active and the array itself is never reset.
module sprite_ram_dp (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_dat,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [256];
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Sampling the array before the same-edge write lands gives old data on a collision.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_bitmap_loader.sv
// Receives checked sprite bitmaps over a byte stream and commits them to the sprite RAM; 1-cycle read latency.
// in_ready drops only while committing; commit advances on cycles where wr_window is high.
module sprite_bitmap_loader
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_BITMAPS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       wr_window,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       load_done,
  output logic       load_error,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] chk_q, chk_d;
  logic [2:0] idx_q, idx_d;
  logic       load_done_q, load_done_d;
  logic       load_error_q, load_error_d;

  logic [7:0] line_buf_q [BITMAP_BYTES];
  logic       buf_we;
  logic       ram_we;
  rd_addr_t   ram_waddr;
  hdr_t       hdr;
  logic       hdr_ok;
  logic       xfer;

  assign in_ready = (state_q != COMMIT);
  assign xfer     = in_valid & in_ready;
  assign hdr      = hdr_t'(in_data);
  assign hdr_ok   = (hdr.magic == MAGIC) && (32'(hdr.idx) < NUM_BITMAPS);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    chk_d        = chk_q;
    idx_d        = idx_q;
    load_done_d  = 1'b0;
    load_error_d = 1'b0;
    buf_we       = 1'b0;
    ram_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok) begin
            state_d = RECV;
            idx_d   = hdr.idx;
          end else begin
            load_error_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (xfer) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ in_data;
          // cnt stays on the last slot; CHECK clears it explicitly.
          if (cnt_q == CNT_LAST) begin
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      CHECK: begin
        if (xfer) begin
          cnt_d = '0;
          if (in_data == chk_q) begin
            state_d = COMMIT;
          end else begin
            load_error_d = 1'b1;
            chk_d        = '0;
            state_d      = IDLE;
          end
        end
      end
      COMMIT: begin
        if (wr_window) begin
          ram_we = 1'b1;
          if (cnt_q == CNT_LAST) begin
            load_done_d = 1'b1;
            cnt_d       = '0;
            chk_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_waddr.bitmap = idx_q;
    ram_waddr.row    = cnt_q[4:1];
    ram_waddr.half   = cnt_q[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      chk_q        <= '0;
      idx_q        <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      chk_q        <= chk_d;
      idx_q        <= idx_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf_q[cnt_q] <= in_data;
    end
  end

  sprite_ram_dp u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_dat  (line_buf_q[cnt_q]),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_bitmap_loader.sv
// Randomized scoreboard bench for sprite_bitmap_loader: expected pulses and reads are queued at
// stimulus time and popped by an independent monitor that samples on the falling edge.
module tb_sprite_bitmap_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       wr_window = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       load_done;
  logic       load_error;
  logic       busy;

  sprite_bitmap_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_window  (wr_window),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .load_done  (load_done),
    .load_error (load_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit is_done;
    int cyc;
  } ev_t;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } rd_t;

  ev_t        ev_q [$];
  rd_t        rd_q [$];
  logic [7:0] ref_mem   [256];
  bit         ref_known [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected pulses / read data as the DUT presents them.
  always @(negedge clk) begin
    ev_t e;
    rd_t r;
    if ((load_done || load_error) && ev_q.size() == 0) begin
      check("unexpected_pulse", {30'd0, load_done, load_error}, 32'd0);
    end else if (ev_q.size() > 0 && (load_done || load_error || ev_q[0].cyc <= cyc)) begin
      e = ev_q.pop_front();
      check("pulse_kind", {30'd0, load_done, load_error}, e.is_done ? 32'd2 : 32'd1);
      check("pulse_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
      r = rd_q.pop_front();
      check("rd_data", {24'd0, rd_data}, {24'd0, r.val});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic issue_read_exp(input logic [7:0] a, input logic [7:0] v);
    rd_addr = a;
    rd_q.push_back('{val: v, cyc: cyc + 1});
  endtask

  task automatic issue_read(input logic [7:0] a);
    rd_addr = a;
    if (ref_known[a]) rd_q.push_back('{val: ref_mem[a], cyc: cyc + 1});
  endtask

  task automatic send_byte(input logic [7:0] b, output int k);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    k = cyc;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // mode 0: wr_window always 1; mode 1: 4 off / 4 on; mode 2: random.
  task automatic run_frame(input logic [2:0] idx, input logic [4:0] magic,
                           input logic [7:0] data [32], input logic [7:0] chk_err,
                           input int mode, input bit probe);
    int         k, j, writes, pstate;
    logic [7:0] ck;
    logic [7:0] a;
    bit         w;
    send_byte({idx, magic}, k);
    if (magic != 5'h1A) begin
      ev_q.push_back('{is_done: 1'b0, cyc: k});
      return;
    end
    ck = 8'h00;
    for (int i = 0; i < 32; i++) begin
      gap();
      send_byte(data[i], k);
      ck ^= data[i];
    end
    gap();
    send_byte(ck ^ chk_err, k);
    if (chk_err != 8'h00) begin
      ev_q.push_back('{is_done: 1'b0, cyc: k});
      @(negedge clk);
      check("err_in_ready", {31'd0, in_ready}, 32'd1);
      check("err_busy", {31'd0, busy}, 32'd0);
      tick();
      return;
    end
    if (mode == 0) ev_q.push_back('{is_done: 1'b1, cyc: k + 32});
    if (mode == 1) ev_q.push_back('{is_done: 1'b1, cyc: k + 64});
    writes = 0;
    j      = 0;
    pstate = 0;
    while (writes < 32) begin
      j++;
      if (mode == 0 || j > 150) w = 1'b1;
      else if (mode == 1) w = (((j - 1) / 4) % 2) == 1;
      else w = 1'($urandom_range(0, 1));
      wr_window = w;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      if (probe && pstate == 0 && w && writes == 3) begin
        issue_read_exp({idx, 5'd3}, ref_mem[{idx, 5'd3}]);
        pstate = 1;
      end else if (pstate == 1) begin
        issue_read_exp({idx, 5'd3}, data[3]);
        pstate = 2;
      end else begin
        a = 8'($urandom);
        if (a[7:5] != idx) issue_read(a);
      end
      if (w) begin
        writes++;
        if (writes == 32 && mode == 2) ev_q.push_back('{is_done: 1'b1, cyc: cyc + 1});
      end
      @(negedge clk);
      check("commit_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    wr_window = 1'($urandom_range(0, 1));
    for (int i = 0; i < 32; i++) begin
      ref_mem[{idx, 5'(i)}]   = data[i];
      ref_known[{idx, 5'(i)}] = 1'b1;
    end
  endtask

  logic [7:0] d  [32];
  logic [7:0] d2 [32];

  initial begin
    int         k;
    int         sel;
    logic [4:0] m;
    logic [2:0] ix;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_load_error", {31'd0, load_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Load idx1 with 0x00..0x1F, then read back address 0x25
    for (int i = 0; i < 32; i++) d[i] = 8'(i);
    run_frame(3'd1, 5'h1A, d, 8'h00, 0, 1'b0);
    issue_read_exp(8'h25, 8'h05);
    tick();
    issue_read(8'h3F);
    tick();

    // Same frame with a corrupted checksum leaves idx1 untouched
    run_frame(3'd1, 5'h1A, d, 8'hFF, 0, 1'b0);
    for (int i = 0; i < 32; i += 5) begin
      issue_read({3'd1, 5'(i)});
      tick();
    end

    // Bad magic, immediately followed by a valid header
    send_byte(8'h3B, k);
    ev_q.push_back('{is_done: 1'b0, cyc: k});
    for (int i = 0; i < 32; i++) d[i] = 8'($urandom);
    run_frame(3'd2, 5'h1A, d, 8'h00, 0, 1'b0);

    // Commit paced by a toggling write window
    for (int i = 0; i < 32; i++) d[i] = 8'($urandom);
    run_frame(3'd3, 5'h1A, d, 8'h00, 1, 1'b0);
    issue_read(8'h7C);
    tick();

    // Read-before-write on address 0x03 during an idx0 commit
    for (int i = 0; i < 32; i++) d[i] = 8'($urandom);
    run_frame(3'd0, 5'h1A, d, 8'h00, 0, 1'b0);
    for (int i = 0; i < 32; i++) d2[i] = 8'($urandom);
    d2[3] = ~d[3];
    run_frame(3'd0, 5'h1A, d2, 8'h00, 0, 1'b1);
    issue_read(8'h03);
    tick();

    // Reset in the middle of a frame
    send_byte({3'd4, 5'h1A}, k);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), k);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) d[i] = 8'($urandom);
    run_frame(3'd4, 5'h1A, d, 8'h00, 0, 1'b0);
    for (int i = 0; i < 32; i += 7) begin
      issue_read({3'd4, 5'(i)});
      tick();
    end

    // Randomized frames
    for (int n = 0; n < 20; n++) begin
      ix  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 99);
      for (int i = 0; i < 32; i++) d[i] = 8'($urandom);
      gap();
      if (sel < 15) begin
        do m = 5'($urandom); while (m == 5'h1A);
        run_frame(ix, m, d, 8'h00, 0, 1'b0);
      end else if (sel < 30) begin
        run_frame(ix, 5'h1A, d, 8'($urandom_range(1, 255)), 0, 1'b0);
      end else begin
        run_frame(ix, 5'h1A, d, 8'h00, $urandom_range(0, 2), 1'b0);
      end
      repeat (4) begin
        issue_read({ix, 5'($urandom_range(0, 31))});
        tick();
      end
    end

    repeat (5) tick();
    check("pending_events", 32'(ev_q.size()), 32'd0);
    check("pending_reads", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
